// File: rtl/rf_pc_seq_pkg.sv
// rf_pc_seq_pkg: shared states, opcodes, ALU codes and instruction field positions for rf_pc_sequencer
package rf_pc_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB} state_t;
  typedef enum logic [2:0] {ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_SLT = 3'd4} alu_op_t;
  typedef enum logic [1:0] {K_SEQ, K_BR, K_JMP} kind_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int REG_W  = 5;
  localparam int FN_W   = 6;
  localparam int IMM_W  = 16;
  localparam int TGT_W  = 26;
endpackage

// File: rtl/rf_pc_seq_decode.sv
// rf_pc_seq_decode: opcode/funct -> control word (ALU op, operand select, dest select, write, kind, illegal)
module rf_pc_seq_decode
  import rf_pc_seq_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       alu_src_imm,
  output logic       dest_rt,
  output logic       wr_en,
  output logic [1:0] kind,
  output logic       bad
);
  always_comb begin
    alu_op = ALU_ADD;
    alu_src_imm = 1'b0;
    dest_rt = 1'b0;
    wr_en = 1'b0;
    kind = K_SEQ;
    bad = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        wr_en = 1'b1;
        case (funct)
          FN_ADD: alu_op = ALU_ADD;
          FN_SUB: alu_op = ALU_SUB;
          FN_AND: alu_op = ALU_AND;
          FN_OR:  alu_op = ALU_OR;
          FN_SLT: alu_op = ALU_SLT;
          default: begin
            wr_en = 1'b0;
            bad = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        alu_src_imm = 1'b1;
        dest_rt = 1'b1;
        wr_en = 1'b1;
      end
      OP_BEQ: begin
        alu_op = ALU_SUB;
        kind = K_BR;
      end
      OP_J: kind = K_JMP;
      default: bad = 1'b1;
    endcase
  end
endmodule

// File: rtl/rf_pc_sequencer.sv
// rf_pc_sequencer: multi-cycle fetch/decode/exec/wb controller for the register file and PC.
// Define ILLEGAL_TRAP_EN to vector illegal instructions to TRAP_VECTOR instead of skipping them.
module rf_pc_sequencer
  import rf_pc_seq_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0040,
  parameter logic [31:0] PC_STEP = 32'd1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] pc_q,
  input  logic        alu_zero,
  output logic [4:0]  read_reg_1,
  output logic [4:0]  read_reg_2,
  output logic        write,
  output logic [4:0]  write_reg,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic [31:0] imm_ext,
  output logic        inc,
  output logic        ld,
  output logic [31:0] pc_data_in,
  output logic        illegal,
  output logic        busy
);
  state_t state, state_n;
  logic [31:0] ir;
  logic zero_q, dest_rt, wr_en, bad, trap;
  logic [1:0] kind;
  rf_pc_seq_decode u_decode (
    .opcode(ir[OP_LSB +: 6]),
    .funct(ir[FN_W-1:0]),
    .alu_op(alu_op),
    .alu_src_imm(alu_src_imm),
    .dest_rt(dest_rt),
    .wr_en(wr_en),
    .kind(kind),
    .bad(bad)
  );
`ifdef ILLEGAL_TRAP_EN
  assign trap = bad;
`else
  assign trap = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
      ir <= '0;
      zero_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_FETCH && fetch_ack) ir <= fetch_instr;
      if (state == S_EXEC) zero_q <= alu_zero;
    end
  end
  // strobes fire only in WB and are killed by a same-cycle clr
  always_comb begin
    state_n = state;
    write = 1'b0;
    inc = 1'b0;
    ld = 1'b0;
    illegal = 1'b0;
    case (state)
      S_IDLE:   state_n = run ? S_FETCH : S_IDLE;
      S_FETCH:  state_n = fetch_ack ? S_DECODE : S_FETCH;
      S_DECODE: state_n = S_EXEC;
      S_EXEC:   state_n = S_WB;
      S_WB: begin
        state_n = run ? S_FETCH : S_IDLE;
        write = !clr && wr_en && write_reg != '0;
        inc = !clr && ((kind == K_SEQ && !trap) || (kind == K_BR && !zero_q));
        ld = !clr && ((kind == K_BR && zero_q) || kind == K_JMP || trap);
        illegal = !clr && bad;
      end
      default: state_n = S_IDLE;
    endcase
  end
  assign fetch_req = state == S_FETCH;
  assign fetch_addr = pc_q;
  assign busy = state != S_IDLE;
  assign read_reg_1 = ir[RS_LSB +: REG_W];
  assign read_reg_2 = ir[RT_LSB +: REG_W];
  assign write_reg = dest_rt ? ir[RT_LSB +: REG_W] : ir[RD_LSB +: REG_W];
  assign imm_ext = {{(32-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  assign pc_data_in = !ld ? '0 : trap ? TRAP_VECTOR :
                      kind == K_JMP ? {pc_q[31:TGT_W], ir[TGT_W-1:0]} : pc_q + PC_STEP + imm_ext;
endmodule

// File: tb/tb_rf_pc_sequencer.sv
// tb_rf_pc_sequencer: directed self-checking bench for rf_pc_sequencer
module tb_rf_pc_sequencer;
  logic clk = 1'b0, clr = 1'b1, run = 1'b0, fetch_ack = 1'b0, alu_zero = 1'b0;
  logic [31:0] fetch_instr = '0, pc_q = '0;
  logic fetch_req, write, alu_src_imm, inc, ld, illegal, busy;
  logic [31:0] fetch_addr, imm_ext, pc_data_in;
  logic [4:0] read_reg_1, read_reg_2, write_reg;
  logic [2:0] alu_op;
  int tests = 0, fails = 0;

  rf_pc_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_instr(fetch_instr), .pc_q(pc_q), .alu_zero(alu_zero),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2), .write(write), .write_reg(write_reg),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .imm_ext(imm_ext), .inc(inc), .ld(ld),
    .pc_data_in(pc_data_in), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // drives one instruction from IDLE/WB/FETCH to its WB cycle; returns cycles spent from first FETCH cycle to WB
  task automatic exec_instr(input logic [31:0] instr, input int fetch_cycles, input logic run_mid,
                            output int cycles, output logic req_held);
    run = 1'b1;
    cycles = fetch_req ? 1 : 0;
    while (!fetch_req && cycles < 10) begin
      step();
      cycles++;
    end
    req_held = fetch_req;
    repeat (fetch_cycles - 1) begin
      step();
      cycles++;
      req_held &= fetch_req;
    end
    fetch_ack = 1'b1;
    fetch_instr = instr;
    step();
    cycles++;
    fetch_ack = 1'b0;
    fetch_instr = 32'hDEAD_BEEF;
    run = run_mid;
    repeat (2) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    run = 1'b0;
    pc_q = '0;
    repeat (2) step();
    tests++; if ({fetch_req, write, inc, ld, illegal, busy, alu_src_imm} !== 7'b0) begin fails++; $display("FAIL reset_strobes: got %b want 0", {fetch_req, write, inc, ld, illegal, busy, alu_src_imm}); end
    tests++; if ({fetch_addr, pc_data_in, imm_ext, read_reg_1, read_reg_2, write_reg, alu_op} !== '0) begin fails++; $display("FAIL reset_values: got %h want 0", {fetch_addr, pc_data_in, imm_ext, read_reg_1, read_reg_2, write_reg, alu_op}); end
    clr = 1'b0;
    step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_hold: busy=%b want 0", busy); end
  endtask

  task automatic test_addi();
    int c;
    logic h;
    pc_q = '0;
    exec_instr(32'h2008_0005, 2, 1'b1, c, h);
    tests++; if (c !== 5) begin fails++; $display("FAIL addi_latency: got %0d want 5", c); end
    tests++; if (h !== 1'b1) begin fails++; $display("FAIL addi_req_held: got %b want 1", h); end
    tests++; if ({read_reg_1, read_reg_2} !== {5'd0, 5'd8}) begin fails++; $display("FAIL addi_rr: got %0d/%0d want 0/8", read_reg_1, read_reg_2); end
    tests++; if ({write, write_reg, alu_src_imm, inc, ld, alu_op} !== {1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 3'd0}) begin fails++; $display("FAIL addi_ctl: w=%b wr=%0d imm=%b inc=%b ld=%b op=%0d want 1/8/1/1/0/0", write, write_reg, alu_src_imm, inc, ld, alu_op); end
    tests++; if (imm_ext !== 32'd5) begin fails++; $display("FAIL addi_imm: got %h want 5", imm_ext); end
  endtask

  task automatic test_add();
    int c;
    logic h;
    step();
    pc_q = 32'h1;
    #1;
    tests++; if ({write, inc, ld, fetch_req} !== 4'b0001) begin fails++; $display("FAIL pulse_end: w/inc/ld/req=%b want 0001", {write, inc, ld, fetch_req}); end
    tests++; if (fetch_addr !== 32'h1) begin fails++; $display("FAIL fetch_addr: got %h want 1", fetch_addr); end
    exec_instr(32'h0022_1820, 1, 1'b1, c, h);
    tests++; if (c !== 4) begin fails++; $display("FAIL add_latency: got %0d want 4", c); end
    tests++; if ({read_reg_1, read_reg_2, write_reg} !== {5'd1, 5'd2, 5'd3}) begin fails++; $display("FAIL add_regs: got %0d/%0d/%0d want 1/2/3", read_reg_1, read_reg_2, write_reg); end
    tests++; if ({alu_op, alu_src_imm, write, inc, ld} !== {3'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin fails++; $display("FAIL add_ctl: op=%0d imm=%b w=%b inc=%b ld=%b want 0/0/1/1/0", alu_op, alu_src_imm, write, inc, ld); end
  endtask

  task automatic test_alu_ops();
    logic [31:0] instrs [4] = '{32'h0022_1822, 32'h0022_1824, 32'h0022_1825, 32'h0022_182A};
    logic [2:0] ops [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    int c;
    logic h;
    for (int i = 0; i < 4; i++) begin
      exec_instr(instrs[i], 1, 1'b1, c, h);
      tests++; if ({alu_op, write, inc} !== {ops[i], 1'b1, 1'b1}) begin fails++; $display("FAIL alu_op_%0d: op=%0d w=%b inc=%b want %0d/1/1", i, alu_op, write, inc, ops[i]); end
    end
  endtask

  task automatic test_beq();
    int c;
    logic h;
    pc_q = 32'h10;
    alu_zero = 1'b1;
    exec_instr(32'h1021_FFFE, 1, 1'b1, c, h);
    tests++; if ({ld, inc, write, alu_op} !== {1'b1, 1'b0, 1'b0, 3'd1}) begin fails++; $display("FAIL beq_taken_ctl: ld=%b inc=%b w=%b op=%0d want 1/0/0/1", ld, inc, write, alu_op); end
    tests++; if (pc_data_in !== 32'h0000_000F) begin fails++; $display("FAIL beq_target: got %h want 0000000f", pc_data_in); end
    tests++; if (imm_ext !== 32'hFFFF_FFFE) begin fails++; $display("FAIL beq_imm: got %h want fffffffe", imm_ext); end
    alu_zero = 1'b0;
    exec_instr(32'h1021_FFFE, 1, 1'b1, c, h);
    tests++; if ({ld, inc, write} !== 3'b010) begin fails++; $display("FAIL beq_not_taken: ld/inc/w=%b want 010", {ld, inc, write}); end
  endtask

  task automatic test_jump();
    int c;
    logic h;
    pc_q = 32'hF000_0004;
    exec_instr(32'h0800_0100, 1, 1'b1, c, h);
    tests++; if ({ld, inc, write} !== 3'b100) begin fails++; $display("FAIL j_ctl: ld/inc/w=%b want 100", {ld, inc, write}); end
    tests++; if (pc_data_in !== 32'hF000_0100) begin fails++; $display("FAIL j_target: got %h want f0000100", pc_data_in); end
  endtask

  task automatic test_illegal();
    int c;
    logic h;
    pc_q = 32'h20;
    exec_instr(32'hFC00_0000, 1, 1'b1, c, h);
    tests++; if ({illegal, write} !== 2'b10) begin fails++; $display("FAIL ill_op: illegal/w=%b want 10", {illegal, write}); end
`ifdef ILLEGAL_TRAP_EN
    tests++; if ({ld, inc, pc_data_in} !== {1'b1, 1'b0, 32'h40}) begin fails++; $display("FAIL ill_trap: ld=%b inc=%b pc=%h want 1/0/40", ld, inc, pc_data_in); end
`else
    tests++; if ({ld, inc, pc_data_in} !== {1'b0, 1'b1, 32'h0}) begin fails++; $display("FAIL ill_skip: ld=%b inc=%b pc=%h want 0/1/0", ld, inc, pc_data_in); end
`endif
    step();
    tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL ill_pulse: got %b want 0", illegal); end
    exec_instr(32'h0022_1821, 1, 1'b1, c, h);
    tests++; if ({illegal, write} !== 2'b10) begin fails++; $display("FAIL ill_funct: illegal/w=%b want 10", {illegal, write}); end
  endtask

  task automatic test_zero_reg();
    int c;
    logic h;
    exec_instr(32'h0022_0020, 1, 1'b0, c, h);
    tests++; if ({write_reg, write, inc, ld} !== {5'd0, 1'b0, 1'b1, 1'b0}) begin fails++; $display("FAIL r0_write: wr=%0d w=%b inc=%b ld=%b want 0/0/1/0", write_reg, write, inc, ld); end
    step();
    tests++; if ({busy, fetch_req} !== 2'b00) begin fails++; $display("FAIL run_low_idle: busy/req=%b want 00", {busy, fetch_req}); end
  endtask

  task automatic test_clr();
    run = 1'b1;
    step();
    fetch_ack = 1'b1;
    fetch_instr = 32'h0022_1820;
    step();
    fetch_ack = 1'b0;
    step();
    clr = 1'b1;
    step();
    tests++; if ({busy, write, inc, ld} !== 4'b0000) begin fails++; $display("FAIL clr_exec: busy/w/inc/ld=%b want 0000", {busy, write, inc, ld}); end
    clr = 1'b0;
    step();
    fetch_ack = 1'b1;
    fetch_instr = 32'h0022_1820;
    step();
    fetch_ack = 1'b0;
    repeat (2) step();
    tests++; if (inc !== 1'b1) begin fails++; $display("FAIL clr_wb_pre: inc=%b want 1", inc); end
    clr = 1'b1;
    #1;
    tests++; if ({write, inc, ld} !== 3'b000) begin fails++; $display("FAIL clr_wb_gate: w/inc/ld=%b want 000", {write, inc, ld}); end
    step();
    clr = 1'b0;
    run = 1'b1;
    step();
    tests++; if (fetch_req !== 1'b1) begin fails++; $display("FAIL clr_fetch_pre: req=%b want 1", fetch_req); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    run = 1'b0;
    fetch_ack = 1'b1;
    fetch_instr = 32'h0022_1820;
    repeat (2) step();
    fetch_ack = 1'b0;
    tests++; if ({busy, fetch_req, read_reg_1} !== {1'b0, 1'b0, 5'd0}) begin fails++; $display("FAIL late_ack: busy=%b req=%b rr1=%0d want 0/0/0", busy, fetch_req, read_reg_1); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_add();
    test_alu_ops();
    test_beq();
    test_jump();
    test_illegal();
    test_zero_reg();
    test_clr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
